// File: rtl/cmd_frame_parser.sv
// Host-link command deframer: hunts AA 55 frames, buffers and checksums the payload,
// then replays good frames on the cmd_* bus at no more than one event every two cycles.
module cmd_frame_parser #(
  parameter int unsigned MAX_PAYLOAD    = 256,
  parameter int unsigned TIMEOUT_CYCLES = 60000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  cmd_type,
  output logic [15:0] cmd_length,
  output logic [7:0]  cmd_data,
  output logic [15:0] cmd_data_index,
  output logic        cmd_start,
  output logic        cmd_data_valid,
  output logic        cmd_done,
  input  logic        cmd_ready,
  output logic        frame_err,
  output logic        len_err,
  output logic        timeout_err,
  output logic        busy
);
  localparam int unsigned AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_SYNC0, S_SYNC1, S_TYPE, S_LEN_H, S_LEN_L, S_PAYLOAD, S_CHECK, S_START, S_DATA, S_DONE
  } state_t;

  state_t        state;
  logic [7:0]    pbuf [0:(1<<AW)-1];
  logic [7:0]    type_q;
  logic [7:0]    len_h;
  logic [7:0]    sum;
  logic [15:0]   len_q;
  logic [15:0]   wr_idx;
  logic [15:0]   rd_idx;
  logic [TW-1:0] tcnt;
  logic          accept;
  logic          parsing;
  logic          pulse_prev;

  assign in_ready   = (state != S_START) && (state != S_DATA) && (state != S_DONE);
  assign accept     = in_valid && in_ready;
  assign parsing    = in_ready && (state != S_SYNC0);
  assign pulse_prev = cmd_start | cmd_data_valid | cmd_done;

  always_ff @(posedge clk) begin
    if (state == S_PAYLOAD && accept) pbuf[wr_idx[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_SYNC0;
      type_q         <= '0;
      len_h          <= '0;
      sum            <= '0;
      len_q          <= '0;
      wr_idx         <= '0;
      rd_idx         <= '0;
      tcnt           <= '0;
      cmd_type       <= '0;
      cmd_length     <= '0;
      cmd_data       <= '0;
      cmd_data_index <= '0;
      cmd_start      <= 1'b0;
      cmd_data_valid <= 1'b0;
      cmd_done       <= 1'b0;
      frame_err      <= 1'b0;
      len_err        <= 1'b0;
      timeout_err    <= 1'b0;
      busy           <= 1'b0;
    end else begin
      cmd_start      <= 1'b0;
      cmd_data_valid <= 1'b0;
      cmd_done       <= 1'b0;
      frame_err      <= 1'b0;
      len_err        <= 1'b0;
      timeout_err    <= 1'b0;

      if (accept || state == S_SYNC0) tcnt <= '0;
      else if (parsing)               tcnt <= tcnt + 1'b1;

      if (parsing && !accept && tcnt == TO_LAST) begin
        timeout_err <= 1'b1;
        state       <= S_SYNC0;
        busy        <= 1'b0;
        tcnt        <= '0;
      end else begin
        case (state)
          S_SYNC0: if (accept && in_data == 8'hAA) begin
            state <= S_SYNC1;
            busy  <= 1'b1;
          end
          S_SYNC1: if (accept) begin
            if (in_data == 8'h55) state <= S_TYPE;
            else if (in_data != 8'hAA) begin
              state <= S_SYNC0;
              busy  <= 1'b0;
            end
          end
          S_TYPE: if (accept) begin
            type_q <= in_data;
            sum    <= in_data;
            state  <= S_LEN_H;
          end
          S_LEN_H: if (accept) begin
            len_h <= in_data;
            sum   <= sum + in_data;
            state <= S_LEN_L;
          end
          S_LEN_L: if (accept) begin
            len_q  <= {len_h, in_data};
            sum    <= sum + in_data;
            wr_idx <= '0;
            if (32'({len_h, in_data}) > MAX_PAYLOAD) begin
              len_err <= 1'b1;
              state   <= S_SYNC0;
              busy    <= 1'b0;
            end else if ({len_h, in_data} == 16'd0) state <= S_CHECK;
            else state <= S_PAYLOAD;
          end
          S_PAYLOAD: if (accept) begin
            sum    <= sum + in_data;
            wr_idx <= wr_idx + 1'b1;
            if (wr_idx == len_q - 1'b1) state <= S_CHECK;
          end
          S_CHECK: if (accept) begin
            // cmd_start is raised on the CS edge so it is visible in S_START itself
            if (in_data == sum) begin
              state      <= S_START;
              cmd_start  <= 1'b1;
              cmd_type   <= type_q;
              cmd_length <= len_q;
              rd_idx     <= '0;
            end else begin
              frame_err <= 1'b1;
              state     <= S_SYNC0;
              busy      <= 1'b0;
            end
          end
          S_START: state <= S_DATA;
          S_DATA: if (!pulse_prev) begin
            if (rd_idx == cmd_length) begin
              cmd_done <= 1'b1;
              state    <= S_DONE;
            end else if (cmd_ready) begin
              cmd_data_valid <= 1'b1;
              cmd_data       <= pbuf[rd_idx[AW-1:0]];
              cmd_data_index <= rd_idx;
              rd_idx         <= rd_idx + 1'b1;
            end
          end
          S_DONE: begin
            state <= S_SYNC0;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_SYNC0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cmd_frame_parser.sv
// Bench for cmd_frame_parser: fixed frame table, hand-written corner sequences and
// random frames checked by an event scoreboard plus pacing/stability monitors.
module tb_cmd_frame_parser;
  localparam int unsigned T = 40;
  localparam int K_START = 1, K_VALID = 2, K_DONE = 3, K_FERR = 4, K_LERR = 5, K_TERR = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  cmd_type;
  logic [15:0] cmd_length;
  logic [7:0]  cmd_data;
  logic [15:0] cmd_data_index;
  logic        cmd_start, cmd_data_valid, cmd_done;
  logic        cmd_ready;
  logic        frame_err, len_err, timeout_err, busy;

  logic rdy_force = 1'b1;
  logic rnd_ready = 1'b0;
  logic rnd_bit = 1'b1;
  logic rdy_edge = 1'b0;
  assign cmd_ready = rnd_ready ? rnd_bit : rdy_force;

  cmd_frame_parser #(.MAX_PAYLOAD(256), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cmd_type(cmd_type), .cmd_length(cmd_length), .cmd_data(cmd_data),
    .cmd_data_index(cmd_data_index), .cmd_start(cmd_start), .cmd_data_valid(cmd_data_valid),
    .cmd_done(cmd_done), .cmd_ready(cmd_ready), .frame_err(frame_err), .len_err(len_err),
    .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rdy_edge <= cmd_ready;
  initial forever begin
    @(negedge clk);
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  typedef struct { int kind; int a; int b; } ev_t;
  ev_t expq[$];
  logic [7:0] fb[$];
  int total = 0, bad = 0;
  int last_acc = 0;
  int t_start, t_done, t_ferr, t_lerr, t_terr;
  int t_valid[$];
  bit prev_pulse = 1'b0, in_replay = 1'b0;
  logic [7:0]  st_type;
  logic [15:0] st_len;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int a, input int b);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b;
    expq.push_back(e);
  endtask

  task automatic got(input int kind, input int a, input int b);
    ev_t e;
    if (expq.size() == 0) begin
      check("unexpected event kind", kind, 0);
      return;
    end
    e = expq.pop_front();
    check("event kind", kind, e.kind);
    check("event field a", a, e.a);
    check("event field b", b, e.b);
  endtask

  task automatic clear_ts();
    t_start = -1; t_done = -1; t_ferr = -1; t_lerr = -1; t_terr = -1;
    t_valid.delete();
  endtask

  initial forever begin
    @(posedge clk); #1;
    if (!rst_n) begin
      prev_pulse = 1'b0;
      in_replay  = 1'b0;
    end else begin
      if (cmd_start) begin
        in_replay = 1'b1;
        st_type = cmd_type;
        st_len  = cmd_length;
        t_start = cyc;
        got(K_START, int'(cmd_type), int'(cmd_length));
      end
      if (in_replay) begin
        check("in_ready during replay", int'(in_ready), 0);
        check("cmd_type/cmd_length stable", int'({cmd_type, cmd_length}), int'({st_type, st_len}));
      end
      if (cmd_data_valid) begin
        check("pacing gap before valid", int'(prev_pulse), 0);
        check("cmd_ready before valid", int'(rdy_edge), 1);
        t_valid.push_back(cyc);
        got(K_VALID, int'(cmd_data), int'(cmd_data_index));
      end
      if (cmd_done) begin
        check("pacing gap before done", int'(prev_pulse), 0);
        t_done = cyc;
        got(K_DONE, 0, 0);
        in_replay = 1'b0;
      end
      if (frame_err)   begin t_ferr = cyc; got(K_FERR, 0, 0); end
      if (len_err)     begin t_lerr = cyc; got(K_LERR, 0, 0); end
      if (timeout_err) begin t_terr = cyc; got(K_TERR, 0, 0); end
      prev_pulse = cmd_start | cmd_data_valid | cmd_done;
    end
  end

  task automatic put_byte(input logic [7:0] b);
    int n = 0;
    in_data = b;
    in_valid = 1'b1;
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready wait budget", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    last_acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic send_fb(input int gap_max);
    for (int i = 0; i < fb.size(); i++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      put_byte(fb[i]);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("expected events outstanding", expq.size(), 0);
    expq.delete();
    repeat (3) @(negedge clk);
  endtask

  // mode 0: good frame, 1: corrupted checksum, 2: oversize header only
  task automatic make_frame(input logic [7:0] typ, input logic [15:0] len, input int mode);
    int s;
    logic [7:0] p, cs;
    fb.delete();
    fb.push_back(8'hAA); fb.push_back(8'h55); fb.push_back(typ);
    fb.push_back(len[15:8]); fb.push_back(len[7:0]);
    if (mode == 2) begin
      push_ev(K_LERR, 0, 0);
      return;
    end
    s = int'(typ) + int'(len[15:8]) + int'(len[7:0]);
    if (mode == 0) push_ev(K_START, int'(typ), int'(len));
    for (int i = 0; i < int'(len); i++) begin
      p = 8'($urandom);
      fb.push_back(p);
      s += int'(p);
      if (mode == 0) push_ev(K_VALID, int'(p), i);
    end
    cs = 8'(s % 256);
    if (mode == 1) begin
      cs = cs + 8'($urandom_range(1, 255));
      push_ev(K_FERR, 0, 0);
    end else push_ev(K_DONE, 0, 0);
    fb.push_back(cs);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " cmd_type"}, int'(cmd_type), 0);
    check({tag, " cmd_length"}, int'(cmd_length), 0);
    check({tag, " cmd_data"}, int'(cmd_data), 0);
    check({tag, " cmd_data_index"}, int'(cmd_data_index), 0);
    check({tag, " pulses/busy"},
          int'({cmd_start, cmd_data_valid, cmd_done, frame_err, len_err, timeout_err, busy}), 0);
    check({tag, " in_ready"}, int'(in_ready), 1);
  endtask

  typedef struct {
    int          n;
    logic [127:0] bytes;
    int          err;
    logic [7:0]  typ;
    logic [15:0] len;
    int          off;
  } vec_t;

  function automatic logic [7:0] vbyte(input vec_t r, input int i);
    return r.bytes[8*(r.n-1-i) +: 8];
  endfunction

  initial begin
    vec_t vt [7];
    int n, stall_v, mode, nj;
    bit found;
    logic [7:0] j;

    vt[0] = '{9, 128'hAA55080003414243D1, 0, 8'h08, 16'd3, 5};
    vt[1] = '{9, 128'hAA55080003414243D2, 1, 8'h00, 16'd0, 0};
    vt[2] = '{9, 128'hAA55080003414243D1, 0, 8'h08, 16'd3, 5};
    vt[3] = '{6, 128'hAA5509000009,       0, 8'h09, 16'd0, 5};
    vt[4] = '{5, 128'hAA55070101,         2, 8'h00, 16'd0, 0};
    vt[5] = '{8, 128'h13AAAA5507000007,   0, 8'h07, 16'd0, 8};
    vt[6] = '{8, 128'hAA55FF0002FFFFFF,   0, 8'hFF, 16'd2, 5};

    clear_ts();
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      clear_ts();
      if (vt[v].err == 1) push_ev(K_FERR, 0, 0);
      else if (vt[v].err == 2) push_ev(K_LERR, 0, 0);
      else begin
        push_ev(K_START, int'(vt[v].typ), int'(vt[v].len));
        for (int i = 0; i < int'(vt[v].len); i++)
          push_ev(K_VALID, int'(vbyte(vt[v], vt[v].off + i)), i);
        push_ev(K_DONE, 0, 0);
      end
      for (int i = 0; i < vt[v].n; i++) put_byte(vbyte(vt[v], i));
      drain();
      if (vt[v].err == 0) begin
        check("start latency after CS", t_start, last_acc);
        check("valid count", t_valid.size(), int'(vt[v].len));
        for (int i = 0; i < t_valid.size(); i++)
          check("valid spacing", t_valid[i] - t_start, 2 * (i + 1));
        check("done spacing", t_done - t_start, 2 * (int'(vt[v].len) + 1));
      end else if (vt[v].err == 1) begin
        check("frame_err latency after CS", t_ferr, last_acc);
        check("no start on bad CS", t_start, -1);
      end else begin
        check("len_err latency after LEN_L", t_lerr, last_acc);
      end
    end

    // backpressure: stall after index 3 for 10 cycles
    clear_ts();
    make_frame(8'h21, 16'd16, 0);
    send_fb(0);
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      if (cmd_data_valid && cmd_data_index == 16'd3) found = 1'b1;
    end
    check("reached index 3", int'(found), 1);
    rdy_force = 1'b0;
    stall_v = 0;
    repeat (10) begin
      @(negedge clk);
      if (cmd_data_valid) stall_v++;
    end
    check("valids during stall", stall_v, 0);
    rdy_force = 1'b1;
    drain();
    check("backpressure valid count", t_valid.size(), 16);

    // inter-byte timeout inside payload
    clear_ts();
    push_ev(K_TERR, 0, 0);
    fb = '{8'hAA, 8'h55, 8'h01, 8'h00, 8'h05, 8'h11, 8'h22};
    send_fb(0);
    n = 0;
    while (t_terr < 0 && n < int'(T) + 50) begin
      @(negedge clk);
      n++;
    end
    check("timeout latency", t_terr - last_acc, int'(T));
    check("busy after timeout", int'(busy), 0);
    drain();

    // reset in the middle of a stalled replay
    clear_ts();
    rdy_force = 1'b0;
    make_frame(8'h33, 16'd4, 0);
    while (expq.size() > 1) void'(expq.pop_back());
    send_fb(0);
    n = 0;
    while (t_start < 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle("mid-replay reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rdy_force = 1'b1;
    repeat (30) @(negedge clk);
    check("no done after reset", t_done, -1);
    drain();

    // random frames with random cmd_ready, then a maximum-length frame
    rnd_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      clear_ts();
      n = $urandom_range(0, 9);
      mode = (n < 7) ? 0 : (n < 9) ? 1 : 2;
      if (mode == 2) make_frame(8'($urandom), 16'($urandom_range(257, 65535)), 2);
      else make_frame(8'($urandom), 16'($urandom_range(0, 24)), mode);
      nj = $urandom_range(0, 2);
      for (int k = 0; k < nj; k++) begin
        j = 8'($urandom);
        if (j == 8'hAA) j = 8'h00;
        fb.push_front(j);
      end
      send_fb(2);
      drain();
    end
    clear_ts();
    make_frame(8'h5A, 16'd256, 0);
    send_fb(0);
    drain();
    check("max-length valid count", t_valid.size(), 256);
    rnd_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cmd_frame_parser.md
# cmd_frame_parser

Front-end command deframer that feeds the `cmd_*` bus consumed by the peripheral handlers (UART, and later SPI/I2C/PWM). It accepts a raw byte stream from the host link (USB CDC/FIFO bridge) and hunts for frames. Each payload is buffered in full and its checksum verified. Only a good frame is replayed to the handlers as `cmd_start`, a sequence of `cmd_data_valid` beats, then `cmd_done`, paced by `cmd_ready`.

## Interface
- `MAX_PAYLOAD`, 256: payload buffer depth in bytes. Larger frames are rejected.
- `TIMEOUT_CYCLES`, 60000: inter-byte timeout in clk cycles (1 ms at 60 MHz).
- `clk` in 1: system clock, 60 MHz.
- `rst_n` in 1: reset, asynchronous, active-low. One clock; no other clock domain.
- `in_data` in 8: host stream byte.
- `in_valid` in 1: `in_data` valid. A byte is accepted when `in_valid && in_ready`.
- `in_ready` out 1: parser can accept a byte.
- `cmd_type` out 8: command code of the frame being replayed.
- `cmd_length` out 16: payload length.
- `cmd_data` out 8: payload byte.
- `cmd_data_index` out 16: index of `cmd_data` within the payload, starting at 0.
- `cmd_start` out 1: one-cycle pulse that starts a command.
- `cmd_data_valid` out 1: one-cycle pulse per payload byte.
- `cmd_done` out 1: one-cycle pulse that ends a command.
- `cmd_ready` in 1: handlers can accept data (OR of all handlers' `cmd_ready`).
- `frame_err` out 1: one-cycle pulse on checksum mismatch.
- `len_err` out 1: one-cycle pulse when length > `MAX_PAYLOAD`.
- `timeout_err` out 1: one-cycle pulse on inter-byte timeout.
- `busy` out 1: high in any state other than S_SYNC0.

## Operation
- Frame format: `AA 55 TYPE LEN_H LEN_L PAYLOAD[LEN] CS`.
  - Length is big-endian.
  - CS = 8-bit sum (mod 256) of TYPE, LEN_H, LEN_L and all payload bytes.
- States and transitions on each accepted byte:
  - S_SYNC0: `AA` -> S_SYNC1. Any other byte stays in S_SYNC0.
  - S_SYNC1: `55` -> S_TYPE. `AA` stays in S_SYNC1. Any other byte -> S_SYNC0.
  - S_TYPE: latch type, seed the sum -> S_LEN_H.
  - S_LEN_H -> S_LEN_L.
  - S_LEN_L: latch length.
    - If length > `MAX_PAYLOAD`: `len_err` pulse, -> S_SYNC0.
    - Else if length = 0 -> S_CHECK.
    - Else -> S_PAYLOAD.
  - S_PAYLOAD: write the byte to `buf[wr_idx]` and add it to the sum. After byte LEN-1 -> S_CHECK.
  - S_CHECK: byte == sum -> S_START. Otherwise `frame_err` pulse, -> S_SYNC0.
- Replay sequence:
  - S_START: `cmd_start` = 1 for one cycle, -> S_DATA.
  - S_DATA: issue bytes 0..LEN-1 from the buffer in order.
  - S_DONE: `cmd_done` = 1 for one cycle, -> S_SYNC0.
- `cmd_type` and `cmd_length` are stable from the `cmd_start` cycle through the `cmd_done` cycle.
- Pacing rule: a pulse (`cmd_data_valid` or `cmd_done`) is issued only if the previous cycle carried no `cmd_start`, `cmd_data_valid` or `cmd_done` pulse. This gives at most one event every 2 cycles, which lets handler FIFO counts settle.
- `cmd_data_valid` additionally requires `cmd_ready` = 1, sampled in the cycle before the pulse.
- `cmd_done` ignores `cmd_ready`. With LEN = 0, `cmd_done` follows `cmd_start` by exactly 2 cycles.
- `in_ready` = 1 in S_SYNC0 through S_CHECK, and 0 in S_START/S_DATA/S_DONE. Host bytes stall during replay and none are dropped.
- Timeout:
  - The counter clears on every accepted byte and in S_SYNC0.
  - It increments in S_SYNC1 through S_CHECK when no byte is accepted.
  - At `TIMEOUT_CYCLES`: `timeout_err` pulse, -> S_SYNC0, partial frame discarded.
  - There is no timeout during replay.
- Sum arithmetic is 8-bit wrap-around. `wr_idx` and `rd_idx` are 16-bit, and the buffer is addressed by the low `$clog2(MAX_PAYLOAD)` bits.

## Timing
- Reset values:
  - `cmd_*` outputs, `frame_err`, `len_err`, `timeout_err`, `busy` = 0.
  - State = S_SYNC0.
  - `in_ready` = 1 (combinational decode of S_SYNC0).
- All outputs are registered except `in_ready`.
- Latency:
  - `cmd_start` is asserted in the cycle after the CS byte is accepted.
  - First `cmd_data_valid` is no earlier than 2 cycles after `cmd_start`.
- Back-to-back frames: the next frame's `AA` may be accepted in the cycle after `cmd_done`.
- Reset asserted mid-frame or mid-replay: immediate return to reset values. No `cmd_done` is issued for the aborted command.
- `cmd_ready` deasserted mid-replay: no `cmd_data_valid` is issued while it is low. Replay resumes at the same `rd_idx` with order preserved.

## Test plan
- Good frame `AA 55 08 00 03 41 42 43 D1` with `cmd_ready` = 1 -> `cmd_start` with type 08 and length 3. Then valids carrying 41/42/43 at index 0/1/2, spaced 2 cycles apart. Then `cmd_done` 2 cycles after the last valid. `in_ready` is low throughout the replay.
- Same frame with CS = `D2` -> `frame_err` pulse after CS, no `cmd_start`. The good frame sent immediately afterwards is replayed correctly.
- Zero-length `AA 55 09 00 00 09` -> `cmd_start`, `cmd_done` exactly 2 cycles later, no `cmd_data_valid`.
- Backpressure: 16-byte payload with `cmd_ready` held low for 10 cycles after byte 4 -> no valid during the stall. Bytes 4..15 follow with correct data and indices.
- Oversize LEN = `0101` (`MAX_PAYLOAD` = 256) -> `len_err` after LEN_L. Then `13 AA AA 55 07 00 00 07` resyncs and yields `cmd_start` with type 07.
- Stream stops after 2 payload bytes -> `timeout_err` exactly `TIMEOUT_CYCLES` cycles after the last accepted byte. Separately, `rst_n` pulsed low during S_DATA -> all outputs return to 0 and `in_ready` = 1.
